// File: rtl/lsu_pkg.sv
// Shared constants, FSM encoding and access-legality helper for the MEM-stage
// load/store unit.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Misaligned address for the access size, or a funct3 with no load/store meaning.
  function automatic logic bad_access(input logic       is_load,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    unique case (funct3)
      3'b000:        bad = 1'b0;
      3'b001:        bad = addr_lo[0];
      3'b010:        bad = |addr_lo;
      3'b100:        bad = !is_load;
      3'b101:        bad = !is_load || addr_lo[0];
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    data_o   = rdata_i;
    shifted  = rdata_i >> {addr_lo_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (funct3_i)
      LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      data_o = {{16{half_sel[15]}}, half_sel};
      LBU:     data_o = {24'd0, byte_sel};
      LHU:     data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives a ready/valid data-memory port, aligns and
// extends load data into WB, and stalls the pipeline while an access is in flight.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] WB_load_data,
  output logic        misaligned,
  output logic        bus_err
);

  lsu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] wb_q, wb_d;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;
  logic        load_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q, wstrb_in;
  logic [31:0] wdata_q, wdata_in;

  logic        access, bad, start, busy, timeout_hit, complete, capture;
  logic [31:0] aligned;

  assign access = MEM_MemRead | MEM_MemWrite;
  assign bad    = bad_access(MEM_MemRead, MEM_funct3, MEM_addr[1:0]);
  assign start  = (state_q == IDLE) && access && !bad;
  assign busy   = (state_q == REQ) || (state_q == WAIT);

  assign timeout_hit = busy && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    complete = 1'b0;
    capture  = 1'b0;
    if (state_q == REQ) begin
      complete = dmem_ready && (!load_q || dmem_rvalid);
      capture  = load_q && dmem_ready && dmem_rvalid;
    end else if (state_q == WAIT) begin
      complete = dmem_rvalid;
      capture  = dmem_rvalid;
    end
  end

  always_comb begin
    wstrb_in = 4'b1111;
    wdata_in = MEM_store_data;
    unique case (MEM_funct3)
      SB: begin
        wstrb_in = 4'b0001 << MEM_addr[1:0];
        wdata_in = {4{MEM_store_data[7:0]}};
      end
      SH: begin
        wstrb_in = 4'b0011 << {MEM_addr[1], 1'b0};
        wdata_in = {2{MEM_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (alo_q),
    .funct3_i  (f3_q),
    .data_o    (aligned)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; completion is tested before timeout so it wins a tie.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ: begin
        if (complete)                   state_d = DONE;
        else if (timeout_hit)           state_d = DONE;
        else if (load_q && dmem_ready)  state_d = WAIT;
      end
      WAIT: if (complete || timeout_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    dmem_req   = (state_q == REQ);
    dmem_we    = dmem_req && !load_q;
    dmem_addr  = dmem_req ? addr_q : 32'd0;
    dmem_wstrb = dmem_we ? wstrb_q : 4'd0;
    dmem_wdata = dmem_we ? wdata_q : 32'd0;
    mem_stall  = start || busy;
    misaligned = (state_q == IDLE) && access && bad;
    bus_err    = timeout_hit && !complete;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if (busy)       cnt_d = cnt_q + CNT_W'(1);
    wb_d = wb_q;
    if (capture)      wb_d = aligned;
    else if (bus_err) wb_d = 32'd0;
  end

  // Request fields are frozen at issue so the bus sees them stable until ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      wb_q    <= 32'd0;
      f3_q    <= 3'd0;
      alo_q   <= 2'd0;
      load_q  <= 1'b0;
      addr_q  <= 32'd0;
      wstrb_q <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      wb_q  <= wb_d;
      if (start) begin
        f3_q    <= MEM_funct3;
        alo_q   <= MEM_addr[1:0];
        load_q  <= MEM_MemRead;
        addr_q  <= {MEM_addr[31:2], 2'b00};
        wstrb_q <= wstrb_in;
        wdata_q <= wdata_in;
      end
    end
  end

  assign WB_load_data = wb_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with hand-computed expectations, TIMEOUT set to 4.
module tb_mem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_MemRead, MEM_MemWrite;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_addr, MEM_store_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall, misaligned, bus_err;
  logic [31:0] WB_load_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_MemWrite   (MEM_MemWrite),
    .MEM_funct3     (MEM_funct3),
    .MEM_addr       (MEM_addr),
    .MEM_store_data (MEM_store_data),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_wdata     (dmem_wdata),
    .dmem_ready     (dmem_ready),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .mem_stall      (mem_stall),
    .WB_load_data   (WB_load_data),
    .misaligned     (misaligned),
    .bus_err        (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    MEM_MemRead    = 1'b0;
    MEM_MemWrite   = 1'b0;
    MEM_funct3     = 3'd0;
    MEM_addr       = 32'd0;
    MEM_store_data = 32'd0;
    dmem_ready     = 1'b0;
    dmem_rvalid    = 1'b0;
    dmem_rdata     = 32'd0;
  endtask

  // Load whose memory answers ready and rvalid together on the first REQ cycle.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    int n;
    tick();
    clear_inputs();
    MEM_MemRead = 1'b1;
    MEM_funct3  = f3;
    MEM_addr    = addr;
    dmem_ready  = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    @(negedge clk);
    check({tag, "_issue_stall"}, mem_stall, 1);
    n = 0;
    do begin
      tick();
      @(negedge clk);
      n++;
    end while (mem_stall && n < 10);
    check({tag, "_done"}, mem_stall, 0);
    check(tag, WB_load_data, exp);
    tick();
    clear_inputs();
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    tick();
    clear_inputs();
    MEM_MemWrite   = 1'b1;
    MEM_funct3     = f3;
    MEM_addr       = addr;
    MEM_store_data = data;
    dmem_ready     = 1'b1;
    @(negedge clk);
    check({tag, "_idle_stall"}, mem_stall, 1);
    check({tag, "_idle_req"}, dmem_req, 0);
    tick();
    @(negedge clk);
    check({tag, "_req"}, dmem_req, 1);
    check({tag, "_we"}, dmem_we, 1);
    check({tag, "_addr"}, dmem_addr, exp_addr);
    check({tag, "_wstrb"}, dmem_wstrb, exp_strb);
    check({tag, "_wdata"}, dmem_wdata, exp_wdata);
    tick();
    @(negedge clk);
    check({tag, "_done_stall"}, mem_stall, 0);
    check({tag, "_done_wstrb"}, dmem_wstrb, 0);
    check({tag, "_done_we"}, dmem_we, 0);
    tick();
    clear_inputs();
  endtask

  task automatic run_bad(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr);
    tick();
    clear_inputs();
    MEM_MemRead  = rd;
    MEM_MemWrite = wr;
    MEM_funct3   = f3;
    MEM_addr     = addr;
    dmem_ready   = 1'b1;
    @(negedge clk);
    check({tag, "_pulse"}, misaligned, 1);
    check({tag, "_stall"}, mem_stall, 0);
    check({tag, "_req"}, dmem_req, 0);
    tick();
    clear_inputs();
    @(negedge clk);
    check({tag, "_pulse_end"}, misaligned, 0);
    check({tag, "_no_req"}, dmem_req, 0);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #3;
    check("rst_stall", mem_stall, 0);
    check("rst_req", dmem_req, 0);
    check("rst_wb", WB_load_data, 0);
    check("rst_buserr", bus_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // LW 0x100: IDLE, REQ(ready), WAIT, WAIT(rvalid) -> four stall cycles, then DONE.
    tick();
    MEM_MemRead = 1'b1;
    MEM_funct3  = LW;
    MEM_addr    = 32'h100;
    @(negedge clk);
    check("lw_c1_stall", mem_stall, 1);
    check("lw_c1_req", dmem_req, 0);
    dmem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("lw_c2_req", dmem_req, 1);
    check("lw_c2_addr", dmem_addr, 32'h100);
    check("lw_c2_we", dmem_we, 0);
    check("lw_c2_stall", mem_stall, 1);
    tick();
    dmem_ready = 1'b0;
    @(negedge clk);
    check("lw_c3_req", dmem_req, 0);
    check("lw_c3_stall", mem_stall, 1);
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    check("lw_c4_stall", mem_stall, 1);
    tick();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("lw_done_stall", mem_stall, 0);
    check("lw_data", WB_load_data, 32'hDEADBEEF);
    tick();
    clear_inputs();

    run_load("lb_103",  LB,  32'h103, 32'h80FF7F01, 32'hFFFFFF80);
    run_load("lbu_103", LBU, 32'h103, 32'h80FF7F01, 32'h00000080);
    run_load("lh_102",  LH,  32'h102, 32'h80FF7F01, 32'hFFFF80FF);
    run_load("lhu_100", LHU, 32'h100, 32'h80FF7F01, 32'h00007F01);
    run_load("lb_101",  LB,  32'h101, 32'h80FF7F01, 32'h0000007F);

    run_store("sb_201", SB, 32'h201, 32'h12345678, 32'h200, 4'b0010, 32'h78787878);
    run_store("sh_202", SH, 32'h202, 32'hAABBCCDD, 32'h200, 4'b1100, 32'hCCDDCCDD);
    run_store("sw_300", SW, 32'h300, 32'hCAFEF00D, 32'h300, 4'b1111, 32'hCAFEF00D);
    check("wb_kept_by_stores", WB_load_data, 32'h0000007F);

    run_bad("lw_102_mis",  1'b1, 1'b0, LW,     32'h102);
    run_bad("lh_101_mis",  1'b1, 1'b0, LH,     32'h101);
    run_bad("ld_f3_011",   1'b1, 1'b0, 3'b011, 32'h100);
    run_bad("st_f3_100",   1'b0, 1'b1, 3'b100, 32'h100);
    run_bad("sh_203_mis",  1'b0, 1'b1, SH,     32'h203);
    run_bad("rdwr_lhu_101", 1'b1, 1'b1, LHU,   32'h101);

    // Timeout: ready never comes; bus_err on the 4th REQ cycle, WB cleared.
    tick();
    MEM_MemRead = 1'b1;
    MEM_funct3  = LW;
    MEM_addr    = 32'h400;
    @(negedge clk);
    check("to_issue_stall", mem_stall, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("to_req%0d_stall", k), mem_stall, 1);
      check($sformatf("to_req%0d_buserr", k), bus_err, (k == 4) ? 1 : 0);
    end
    tick();
    @(negedge clk);
    check("to_done_stall", mem_stall, 0);
    check("to_done_buserr", bus_err, 0);
    check("to_wb_zero", WB_load_data, 0);
    tick();
    clear_inputs();
    @(negedge clk);
    check("to_idle_stall", mem_stall, 0);
    check("to_idle_req", dmem_req, 0);

    // Completion on the timeout cycle wins over bus_err.
    tick();
    MEM_MemRead = 1'b1;
    MEM_funct3  = LW;
    MEM_addr    = 32'h404;
    for (int k = 1; k <= 3; k++) begin
      tick();
    end
    tick();
    dmem_ready  = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h11223344;
    @(negedge clk);
    check("tie_req", dmem_req, 1);
    check("tie_buserr", bus_err, 0);
    tick();
    @(negedge clk);
    check("tie_done_stall", mem_stall, 0);
    check("tie_data", WB_load_data, 32'h11223344);
    tick();
    clear_inputs();

    // Reset while in WAIT, then a stale rvalid after release.
    tick();
    MEM_MemRead = 1'b1;
    MEM_funct3  = LW;
    MEM_addr    = 32'h500;
    dmem_ready  = 1'b1;
    tick();
    tick();
    dmem_ready = 1'b0;
    @(negedge clk);
    check("rw_wait_stall", mem_stall, 1);
    check("rw_wait_req", dmem_req, 0);
    #1;
    clear_inputs();
    rst_n = 1'b0;
    #2;
    check("rw_rst_stall", mem_stall, 0);
    check("rw_rst_wb", WB_load_data, 0);
    tick();
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h00000055;
    @(negedge clk);
    check("rw_stale_stall", mem_stall, 0);
    tick();
    @(negedge clk);
    check("rw_stale_wb", WB_load_data, 0);
    check("rw_stale_req", dmem_req, 0);
    check("rw_stale_stall2", mem_stall, 0);
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
